// File: rtl/gpi_debounce.sv
// gpi_debounce: per-bit two-flop synchroniser and stability counter for board-level inputs.
// Define GPI_DEBOUNCE_EDGE_EN to build the registered rise_o/fall_o edge pulses; otherwise they are tied low.
module gpi_debounce #(
  parameter int Width          = 8,
  parameter int DebounceCycles = 50000
) (
  input  logic             clk_sys_i,
  input  logic             rst_sys_i,
  input  logic [Width-1:0] gp_raw_i,
  output logic [Width-1:0] gp_o,
  output logic [Width-1:0] rise_o,
  output logic [Width-1:0] fall_o
);

  localparam int              CntW    = $clog2(DebounceCycles);
  localparam logic [CntW-1:0] CntMax  = CntW'(DebounceCycles - 32'sd1);
  localparam logic [CntW-1:0] CntOne  = CntW'(32'd1);
  localparam logic [CntW-1:0] CntZero = CntW'(32'd0);

  logic [Width-1:0] s1_r;
  logic [Width-1:0] s2_r;
  logic [Width-1:0] gp_r;
  logic [Width-1:0] gp_nxt_s;
  logic [Width-1:0] upd_s;
  logic [CntW-1:0]  cnt_r     [Width];
  logic [CntW-1:0]  cnt_nxt_s [Width];

  // Per-bit qualification: any agreement with gp_r restarts the count; a full count accepts s2.
  always_comb begin
    upd_s    = {Width{1'b0}};
    gp_nxt_s = gp_r;
    for (int i = 0; i < Width; i++) begin
      cnt_nxt_s[i] = CntZero;
      if (s2_r[i] == gp_r[i]) begin
        cnt_nxt_s[i] = CntZero;
      end else if (cnt_r[i] == CntMax) begin
        cnt_nxt_s[i] = CntZero;
        upd_s[i]     = 1'b1;
        gp_nxt_s[i]  = s2_r[i];
      end else begin
        cnt_nxt_s[i] = cnt_r[i] + CntOne;
      end
    end
  end

  // Synchroniser, debounced level and counter registers.
  always_ff @(posedge clk_sys_i) begin
    if (rst_sys_i) begin
      s1_r <= {Width{1'b0}};
      s2_r <= {Width{1'b0}};
      gp_r <= {Width{1'b0}};
      for (int i = 0; i < Width; i++) begin
        cnt_r[i] <= CntZero;
      end
    end else begin
      s1_r <= gp_raw_i;
      s2_r <= s1_r;
      gp_r <= gp_nxt_s;
      for (int i = 0; i < Width; i++) begin
        cnt_r[i] <= cnt_nxt_s[i];
      end
    end
  end

  assign gp_o = gp_r;

`ifdef GPI_DEBOUNCE_EDGE_EN
  logic [Width-1:0] rise_r;
  logic [Width-1:0] fall_r;

  // Edge pulses registered alongside gp_r so they coincide with the new level.
  always_ff @(posedge clk_sys_i) begin
    if (rst_sys_i) begin
      rise_r <= {Width{1'b0}};
      fall_r <= {Width{1'b0}};
    end else begin
      rise_r <= upd_s & s2_r;
      fall_r <= upd_s & ~s2_r;
    end
  end

  assign rise_o = rise_r;
  assign fall_o = fall_r;
`else
  assign rise_o = {Width{1'b0}};
  assign fall_o = {Width{1'b0}};
`endif

endmodule

// File: tb/tb_gpi_debounce.sv
// Directed self-checking bench for gpi_debounce with Width=8, DebounceCycles=4.
// Edge-pulse expectations follow GPI_DEBOUNCE_EDGE_EN (all-zero when undefined).
module tb_gpi_debounce;

`ifdef GPI_DEBOUNCE_EDGE_EN
  localparam logic [7:0] EM = 8'hFF;
`else
  localparam logic [7:0] EM = 8'h00;
`endif

  logic       clk;
  logic       rst;
  logic [7:0] raw;
  logic [7:0] gp;
  logic [7:0] rise;
  logic [7:0] fall;

  int n_cmp = 0;
  int n_err = 0;

  gpi_debounce #(.Width(8), .DebounceCycles(4)) dut (
    .clk_sys_i (clk),
    .rst_sys_i (rst),
    .gp_raw_i  (raw),
    .gp_o      (gp),
    .rise_o    (rise),
    .fall_o    (fall)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    raw = 8'hFF;
    for (int e = 0; e < 3; e++) begin
      step();
      n_cmp++; if (gp !== 8'h00) begin n_err++; $display("FAIL reset_gp e=%0d got %h exp 00", e, gp); end
      n_cmp++; if (rise !== 8'h00) begin n_err++; $display("FAIL reset_rise e=%0d got %h exp 00", e, rise); end
      n_cmp++; if (fall !== 8'h00) begin n_err++; $display("FAIL reset_fall e=%0d got %h exp 00", e, fall); end
    end
    raw = 8'h00;
    step();
    rst = 1'b0;
    step();
    step();
  endtask

  task automatic test_single_bit();
    logic [7:0] eg, er, ef;
    raw = 8'h01;
    for (int e = 0; e < 8; e++) begin
      step();
      eg = (e >= 5) ? 8'h01 : 8'h00;
      er = (e == 5) ? (8'h01 & EM) : 8'h00;
      n_cmp++; if (gp !== eg) begin n_err++; $display("FAIL single_rise_gp e=%0d got %h exp %h", e, gp, eg); end
      n_cmp++; if (rise !== er) begin n_err++; $display("FAIL single_rise_pulse e=%0d got %h exp %h", e, rise, er); end
      n_cmp++; if (fall !== 8'h00) begin n_err++; $display("FAIL single_rise_fall e=%0d got %h exp 00", e, fall); end
    end
    raw = 8'h00;
    for (int e = 0; e < 8; e++) begin
      step();
      eg = (e >= 5) ? 8'h00 : 8'h01;
      ef = (e == 5) ? (8'h01 & EM) : 8'h00;
      n_cmp++; if (gp !== eg) begin n_err++; $display("FAIL single_fall_gp e=%0d got %h exp %h", e, gp, eg); end
      n_cmp++; if (fall !== ef) begin n_err++; $display("FAIL single_fall_pulse e=%0d got %h exp %h", e, fall, ef); end
      n_cmp++; if (rise !== 8'h00) begin n_err++; $display("FAIL single_fall_rise e=%0d got %h exp 00", e, rise); end
    end
  endtask

  task automatic test_glitch();
    raw = 8'h08;
    for (int e = 0; e < 12; e++) begin
      if (e == 3) raw = 8'h00;
      step();
      n_cmp++; if (gp !== 8'h00) begin n_err++; $display("FAIL glitch_gp e=%0d got %h exp 00", e, gp); end
      n_cmp++; if ((rise | fall) !== 8'h00) begin n_err++; $display("FAIL glitch_edge e=%0d got rise %h fall %h exp 00", e, rise, fall); end
    end
  endtask

  task automatic test_min_pulse();
    logic [7:0] eg, er, ef;
    raw = 8'h08;
    for (int e = 0; e < 14; e++) begin
      if (e == 4) raw = 8'h00;
      step();
      eg = (e >= 5 && e <= 8) ? 8'h08 : 8'h00;
      er = (e == 5) ? (8'h08 & EM) : 8'h00;
      ef = (e == 9) ? (8'h08 & EM) : 8'h00;
      n_cmp++; if (gp !== eg) begin n_err++; $display("FAIL minpulse_gp e=%0d got %h exp %h", e, gp, eg); end
      n_cmp++; if (rise !== er) begin n_err++; $display("FAIL minpulse_rise e=%0d got %h exp %h", e, rise, er); end
      n_cmp++; if (fall !== ef) begin n_err++; $display("FAIL minpulse_fall e=%0d got %h exp %h", e, fall, ef); end
    end
  endtask

  task automatic test_multi_bit();
    logic [7:0] eg, ep;
    raw = 8'hA5;
    for (int e = 0; e < 8; e++) begin
      step();
      eg = (e >= 5) ? 8'hA5 : 8'h00;
      ep = (e == 5) ? (8'hA5 & EM) : 8'h00;
      n_cmp++; if (gp !== eg) begin n_err++; $display("FAIL multi_rise_gp e=%0d got %h exp %h", e, gp, eg); end
      n_cmp++; if (rise !== ep) begin n_err++; $display("FAIL multi_rise_pulse e=%0d got %h exp %h", e, rise, ep); end
      n_cmp++; if (fall !== 8'h00) begin n_err++; $display("FAIL multi_rise_fall e=%0d got %h exp 00", e, fall); end
    end
    raw = 8'h00;
    for (int e = 0; e < 8; e++) begin
      step();
      eg = (e >= 5) ? 8'h00 : 8'hA5;
      ep = (e == 5) ? (8'hA5 & EM) : 8'h00;
      n_cmp++; if (gp !== eg) begin n_err++; $display("FAIL multi_fall_gp e=%0d got %h exp %h", e, gp, eg); end
      n_cmp++; if (fall !== ep) begin n_err++; $display("FAIL multi_fall_pulse e=%0d got %h exp %h", e, fall, ep); end
      n_cmp++; if (rise !== 8'h00) begin n_err++; $display("FAIL multi_fall_rise e=%0d got %h exp 00", e, rise); end
    end
  endtask

  task automatic test_independent();
    logic [7:0] eg, er;
    raw = 8'h01;
    for (int e = 0; e < 10; e++) begin
      if (e == 2) raw = 8'h03;
      step();
      eg = ((e >= 5) ? 8'h01 : 8'h00) | ((e >= 7) ? 8'h02 : 8'h00);
      er = ((e == 5) ? 8'h01 : 8'h00) | ((e == 7) ? 8'h02 : 8'h00);
      er = er & EM;
      n_cmp++; if (gp !== eg) begin n_err++; $display("FAIL indep_gp e=%0d got %h exp %h", e, gp, eg); end
      n_cmp++; if (rise !== er) begin n_err++; $display("FAIL indep_rise e=%0d got %h exp %h", e, rise, er); end
    end
    raw = 8'h00;
    for (int e = 0; e < 8; e++) step();
    n_cmp++; if (gp !== 8'h00) begin n_err++; $display("FAIL indep_clear got %h exp 00", gp); end
  endtask

  task automatic test_reset_mid();
    logic [7:0] eg, er;
    raw = 8'h80;
    for (int e = 0; e < 6; e++) step();
    n_cmp++; if (gp !== 8'h80) begin n_err++; $display("FAIL rstmid_pre got %h exp 80", gp); end
    raw = 8'h81;
    for (int e = 0; e < 4; e++) step();
    n_cmp++; if (gp !== 8'h80) begin n_err++; $display("FAIL rstmid_count got %h exp 80", gp); end
    rst = 1'b1;
    step();
    rst = 1'b0;
    n_cmp++; if (gp !== 8'h00) begin n_err++; $display("FAIL rstmid_gp got %h exp 00", gp); end
    n_cmp++; if ((rise | fall) !== 8'h00) begin n_err++; $display("FAIL rstmid_edge got rise %h fall %h exp 00", rise, fall); end
    for (int e = 0; e < 8; e++) begin
      step();
      eg = (e >= 5) ? 8'h81 : 8'h00;
      er = (e == 5) ? (8'h81 & EM) : 8'h00;
      n_cmp++; if (gp !== eg) begin n_err++; $display("FAIL rstmid_after_gp e=%0d got %h exp %h", e, gp, eg); end
      n_cmp++; if (rise !== er) begin n_err++; $display("FAIL rstmid_after_rise e=%0d got %h exp %h", e, rise, er); end
      n_cmp++; if (fall !== 8'h00) begin n_err++; $display("FAIL rstmid_after_fall e=%0d got %h exp 00", e, fall); end
    end
  endtask

  task automatic test_toggle();
    for (int e = 0; e < 40; e++) begin
      raw = (((e / 2) % 2) == 0) ? 8'h01 : 8'h81;
      step();
      n_cmp++; if (gp !== 8'h81) begin n_err++; $display("FAIL toggle_gp e=%0d got %h exp 81", e, gp); end
      n_cmp++; if ((rise | fall) !== 8'h00) begin n_err++; $display("FAIL toggle_edge e=%0d got rise %h fall %h exp 00", e, rise, fall); end
    end
    raw = 8'h81;
    for (int e = 0; e < 8; e++) step();
    n_cmp++; if (gp !== 8'h81) begin n_err++; $display("FAIL toggle_end got %h exp 81", gp); end
  endtask

  initial begin
    rst = 1'b1;
    raw = 8'h00;
    test_reset();
    test_single_bit();
    test_glitch();
    test_min_pulse();
    test_multi_bit();
    test_independent();
    test_reset_mid();
    test_toggle();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/gpi_debounce.md
GPI_DEBOUNCE -- requirements
Module: gpi_debounce

Interface
REQ-001 The block SHALL have parameter Width, default 8, giving the number of general-purpose input bits (legal range 1..32).
REQ-002 The block SHALL have parameter DebounceCycles, default 50000, giving the consecutive stable cycles required to accept a change (legal range 2..2^20).
REQ-003 The block SHALL have port clk_sys_i, input, 1 bit, system clock; it is the only clock.
REQ-004 The block SHALL have port rst_sys_i, input, 1 bit, reset; it is synchronous and active-high.
REQ-005 The block SHALL have port gp_raw_i, input, Width bits, asynchronous switch/button levels taken directly from board pins.
REQ-006 The block SHALL have port gp_o, output, Width bits, synchronised and debounced levels that feed the demo system gp_i.
REQ-007 The block SHALL have port rise_o, output, Width bits, a one-cycle pulse per bit on each debounced 0->1 transition.
REQ-008 The block SHALL have port fall_o, output, Width bits, a one-cycle pulse per bit on each debounced 1->0 transition.

Function
REQ-009 Each bit of gp_raw_i SHALL pass through a two-flop synchroniser (s1, s2) before any other logic uses it.
REQ-010 Each bit SHALL own an independent counter of width $clog2(DebounceCycles); no state is shared between bits.
REQ-011 Per bit, each cycle with s2 equal to gp_o, the counter SHALL load 0.
REQ-012 Per bit, each cycle with s2 not equal to gp_o and counter below DebounceCycles-1, the counter SHALL increment by 1.
REQ-013 Per bit, each cycle with s2 not equal to gp_o and counter equal to DebounceCycles-1, gp_o SHALL load s2 and the counter SHALL load 0.
REQ-014 The counter SHALL never exceed DebounceCycles-1 and SHALL never wrap.
REQ-015 Latency: gp_raw_i changes before edge 0 and then holds; gp_o SHALL update on edge DebounceCycles+1 and not earlier.
REQ-016 Any return of s2 to gp_o before the count completes SHALL restart qualification from 0, so glitches shorter than DebounceCycles cycles never reach gp_o.
REQ-017 rise_o[i] and fall_o[i] SHALL be registered and assert in the same cycle gp_o[i] shows its new value, for exactly one cycle.
REQ-018 rise_o[i] and fall_o[i] SHALL never be high simultaneously.
REQ-019 Simultaneous changes on several bits SHALL be qualified independently; bits that qualify on the same edge update on the same edge.

Reset
REQ-020 While rst_sys_i is high at a clock edge, s1, s2, gp_o, rise_o, fall_o and all counters SHALL load 0.
REQ-021 Reset asserted mid-count SHALL discard the partial count; after release, qualification SHALL restart from 0 against gp_o = 0.
REQ-022 After reset release, a gp_raw_i bit held at 1 SHALL produce gp_o = 1 and a rise_o pulse on edge DebounceCycles+1 counted from the first non-reset edge.

Configuration
REQ-023 When macro GPI_DEBOUNCE_EDGE_EN is defined, the rise_o/fall_o edge-detect registers SHALL be compiled in as specified above.
REQ-024 When GPI_DEBOUNCE_EDGE_EN is not defined, rise_o and fall_o SHALL be tied to 0, no edge registers SHALL exist, and gp_o behaviour SHALL be unchanged.

Verification (Width=8, DebounceCycles=4, macro defined unless stated)
REQ-025 Bit 0 driven 0->1 and held -> gp_o = 8'h01 on edge 5, rise_o = 8'h01 for exactly that cycle, fall_o stays 8'h00.
REQ-026 Bit 3 pulsed high for 3 cycles, then returned low -> gp_o stays 8'h00; rise_o and fall_o stay 0.
REQ-027 gp_raw_i 8'h00->8'hA5 in one cycle, then held -> gp_o = 8'hA5 and rise_o = 8'hA5 on the same edge; later 8'hA5->8'h00 gives fall_o = 8'hA5 for one cycle.
REQ-028 rst_sys_i asserted for one cycle with a bit's count at 2 -> all outputs 0; the held-high bit reaches gp_o only DebounceCycles+1 edges after release.
REQ-029 Bit 7 toggles every 2 cycles for 40 cycles -> gp_o[7] never changes and the counter never exceeds 3.
REQ-030 Macro undefined, repeat REQ-025 -> gp_o identical to REQ-025; rise_o and fall_o remain 8'h00 throughout.
